cell_bist_ctrl: RTL
===================

// Module: cell_bist_ctrl
// PURPOSE
//  Built-in self-test controller that sits directly upstream of a netlist mapped onto our
//  NOT/NAND/NOR/DFF cell library. Drives the mapped block's inputs with LFSR patterns,
//  compacts its outputs into a MISR signature and reports pass/fail against a golden value.
//  Lets us check each yosys mapping run of a combinational cell cluster in silicon or sim.
// PARAMETERS
//  W       8      stimulus width (STIM), >=2
//  RW      8      response width (RESP), >=2
//  NPAT    255    patterns applied per run, >=1
//  SEED    8'h01  LFSR start value (W bits), nonzero
//  TAPS    8'hB8  Galois feedback mask, stimulus LFSR (W bits)
//  MTAPS   8'hB8  Galois feedback mask, MISR (RW bits)
//  GOLDEN  8'h00  expected signature (RW bits)
// PORTS
//  C      in   1   clock, rising edge
//  RN     in   1   reset, asynchronous, active-low
//  START  in   1   run request, sampled in IDLE or DONE
//  RESP   in   RW  combinational response of the mapped netlist to the current STIM
//  STIM   out  W   registered stimulus to the mapped netlist
//  BUSY   out  1   high while patterns are being applied
//  DONE   out  1   run complete, PASS valid
//  PASS   out  1   signature == GOLDEN, valid only while DONE=1
// BEHAVIOUR
//  - Reset (RN=0, asynchronous): state IDLE, STIM=SEED, MISR=0, count=0, BUSY=0, DONE=0, PASS=0.
//  - FSM states are IDLE, RUN and DONE. All outputs are registered.
//  - IDLE --START=1--> RUN: on that edge STIM=SEED, MISR=0, count=0. BUSY=1 from the next cycle.
//  - RUN, every cycle:
//      MISR  <= ((MISR>>1) ^ (MISR[0] ? MTAPS : 0)) ^ RESP
//      STIM  <= (STIM>>1) ^ (STIM[0] ? TAPS : 0)
//      count <= count + 1
//  - RESP is sampled in the same cycle as the STIM that produced it. The mapped netlist is
//    purely combinational between STIM and RESP.
//  - Exactly NPAT responses are absorbed. On the edge that absorbs pattern NPAT, go to DONE:
//    BUSY=0, DONE=1, PASS=(next MISR == GOLDEN). STIM holds its last advanced value.
//  - Run length: START edge to DONE=1 is NPAT+1 cycles.
//  - DONE holds DONE/PASS until START=1. Then it restarts exactly as from IDLE; DONE drops
//    on the same edge.
//  - START in RUN is ignored. START held high causes back-to-back runs.
//  - Count width is $clog2(NPAT+1). There is no wrap within a run.
//  - The stimulus LFSR is never zero when SEED is nonzero. SEED=0 is illegal (LFSR lock-up);
//    a simulation assertion fires at elaboration.
//  - RN asserted mid-run aborts the run with no partial result; all outputs take reset values.
// CONFIGURATION
//  - CELL_BIST_SIG_OUT_EN defined: adds output port SIG (out, RW bits) = live MISR value.
//    SIG resets to 0 and is readable at any time, for golden-value capture.
//  - Not defined: no SIG port; only PASS exposes the signature result. The rest of the
//    behaviour is identical.
// STRUCTURE
//  - Package cell_bist_pkg holds:
//      the state typedef (IDLE, RUN, DONE)
//      default TAPS/MTAPS constants
//      a function galois_step(value, taps)
//  - Sub-module cell_bist_lfsr (params WIDTH, TAPS; ports C, RN, LOAD, LOADV, EN, DIN, Q) is
//    instantiated twice: as the stimulus LFSR with DIN=0, and as the MISR with DIN=RESP.
//  - The FSM and counter live in cell_bist_ctrl.
// TESTING
//  1. Reset: RN=0 mid-RUN -> BUSY=0, DONE=0, PASS=0, STIM=0x01 immediately (async).
//  2. NPAT=1, RESP tied to STIM: START pulse -> STIM=0x01 applied one cycle; DONE=1 two
//     cycles after START; SIG=0x01.
//  3. NPAT=3, RESP=STIM, GOLDEN=0x5C: STIM sequence 0x01, 0xB8, 0x5C; MISR 0x01, 0x00, 0x5C;
//     DONE=1, PASS=1.
//  4. Same as 3 with GOLDEN=0x5D -> DONE=1, PASS=0.
//  5. Fault injection: NPAT=255, RESP=~(STIM[0]&STIM[1]) vs. RESP bit stuck-at-0
//     -> signatures differ; PASS=1 only for the fault-free run.
//  6. START held high throughout RUN and DONE -> no restart mid-run; new run begins on the
//     cycle after DONE=1; DONE is high for exactly one cycle.

Source files
------------

// File: rtl/cell_bist_pkg.sv
// Shared types and helpers for the cell-library BIST controller (stimulus LFSR + MISR).
package cell_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] DEF_TAPS  = 8'hB8;
   localparam logic [7:0] DEF_MTAPS = 8'hB8;

   // One right-shifting Galois step; callers zero-extend to 32 bits and truncate the result.
   function automatic logic [31:0] galois_step(input logic [31:0] value, input logic [31:0] taps);
      return (value >> 1) ^ (value[0] ? taps : 32'd0);
   endfunction

endpackage

// File: rtl/cell_bist_lfsr.sv
// Galois LFSR with parallel load and data injection; DIN=0 gives a plain LFSR, DIN=response gives a MISR.
module cell_bist_lfsr
   import cell_bist_pkg::*;
#(
   parameter int                 WIDTH = 8,
   parameter logic [WIDTH-1:0]   TAPS  = DEF_TAPS,
   parameter logic [WIDTH-1:0]   INIT  = '0
) (
   input  logic             C,
   input  logic             RN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOADV,
   input  logic             EN,
   input  logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         Q <= INIT;
      end else if (LOAD) begin
         Q <= LOADV;
      end else if (EN) begin
         Q <= WIDTH'(galois_step(32'(Q), 32'(TAPS))) ^ DIN;
      end
   end

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST controller: drives a mapped netlist with LFSR patterns and compacts its response into a MISR.
// Define CELL_BIST_SIG_OUT_EN to expose the live MISR value on output SIG.
module cell_bist_ctrl
   import cell_bist_pkg::*;
#(
   parameter int              W      = 8,
   parameter int              RW     = 8,
   parameter int              NPAT   = 255,
   parameter logic [W-1:0]    SEED   = 8'h01,
   parameter logic [W-1:0]    TAPS   = DEF_TAPS,
   parameter logic [RW-1:0]   MTAPS  = DEF_MTAPS,
   parameter logic [RW-1:0]   GOLDEN = 8'h00
) (
   input  logic          C,
   input  logic          RN,
   input  logic          START,
   input  logic [RW-1:0] RESP,
   output logic [W-1:0]  STIM,
   output logic          BUSY,
   output logic          DONE,
   output logic          PASS,
   output state_t        dbg_state
`ifdef CELL_BIST_SIG_OUT_EN
   ,
   output logic [RW-1:0] SIG
`endif
);

   localparam int            CW   = $clog2(NPAT + 1);
   localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

   if (SEED == '0) begin : g_bad_seed
      $error("cell_bist_ctrl: SEED must be nonzero, a zero LFSR never advances");
   end

   state_t        state;
   logic [CW-1:0] count;
   logic [RW-1:0] misr_q;
   logic [RW-1:0] misr_next;
   logic          load;
   logic          adv;

   // START restarts from both IDLE and DONE; it is ignored while patterns are running.
   assign load      = START && (state != ST_RUN);
   assign adv       = (state == ST_RUN);
   assign misr_next = RW'(galois_step(32'(misr_q), 32'(MTAPS))) ^ RESP;
   assign dbg_state = state;

`ifdef CELL_BIST_SIG_OUT_EN
   assign SIG = misr_q;
`endif

   cell_bist_lfsr #(
      .WIDTH (W),
      .TAPS  (TAPS),
      .INIT  (SEED)
   ) u_stim (
      .C     (C),
      .RN    (RN),
      .LOAD  (load),
      .LOADV (SEED),
      .EN    (adv),
      .DIN   ('0),
      .Q     (STIM)
   );

   cell_bist_lfsr #(
      .WIDTH (RW),
      .TAPS  (MTAPS),
      .INIT  ('0)
   ) u_misr (
      .C     (C),
      .RN    (RN),
      .LOAD  (load),
      .LOADV ('0),
      .EN    (adv),
      .DIN   (RESP),
      .Q     (misr_q)
   );

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state <= ST_IDLE;
         count <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         PASS  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  state <= ST_RUN;
                  count <= '0;
                  BUSY  <= 1'b1;
               end
            end
            ST_RUN: begin
               count <= count + 1'b1;
               if (count == LAST) begin
                  state <= ST_DONE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  PASS  <= (misr_next == GOLDEN);
               end
            end
            ST_DONE: begin
               if (START) begin
                  state <= ST_RUN;
                  count <= '0;
                  BUSY  <= 1'b1;
                  DONE  <= 1'b0;
                  PASS  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
               PASS  <= 1'b0;
            end
         endcase
      end
   end

endmodule
